// File: rtl/miriscv_rvfi_pkg.sv
// ---------------------------------------------------------------------------
// miriscv_rvfi_pkg
// Shared definitions for the RVFI retirement serializer.
//   - Field-width localparams for one retired-instruction record.
//   - rvfi_pkt_t: packed record of one retirement, with order as the MSBs.
//   - PKT_W: flattened width of rvfi_pkt_t, used for FIFO storage and ports.
// ---------------------------------------------------------------------------
package miriscv_rvfi_pkg;

    localparam int ORDER_W = 64;
    localparam int INSN_W  = 32;
    localparam int XLEN    = 32;
    localparam int REG_W   = 5;
    localparam int MASK_W  = 4;

    typedef struct packed {
        logic [ORDER_W-1:0] order;
        logic [INSN_W-1:0]  insn;
        logic               trap;
        logic [XLEN-1:0]    pc_rdata;
        logic [XLEN-1:0]    pc_wdata;
        logic [REG_W-1:0]   rd_addr;
        logic [XLEN-1:0]    rd_wdata;
        logic [XLEN-1:0]    mem_addr;
        logic [MASK_W-1:0]  mem_rmask;
        logic [MASK_W-1:0]  mem_wmask;
        logic [XLEN-1:0]    mem_rdata;
        logic [XLEN-1:0]    mem_wdata;
    } rvfi_pkt_t;

    localparam int PKT_W = $bits(rvfi_pkt_t);

endpackage

// File: rtl/miriscv_rvfi_mpfifo.sv
// ---------------------------------------------------------------------------
// miriscv_rvfi_mpfifo
// Multi-push, single-pop FIFO of rvfi_pkt_t records.
//   clk_i, arst_i    : clock, asynchronous active-high reset
//   push_cnt_i       : number of compacted records offered this cycle
//   push_data_i      : compacted records, record i at [i*PKT_W +: PKT_W]
//   accept_cnt_o     : records actually written (limited by free space)
//   pop_i            : consumer takes the head this cycle (ignored if empty)
//   head_o, valid_o  : entry at the read pointer, and non-empty flag
//   level_o          : current occupancy
// ---------------------------------------------------------------------------
module miriscv_rvfi_mpfifo
    import miriscv_rvfi_pkg::*;
#(
    parameter int NRET  = 2,
    parameter int DEPTH = 16
) (
    input  logic                         clk_i,
    input  logic                         arst_i,
    input  logic [$clog2(NRET+1)-1:0]    push_cnt_i,
    input  logic [NRET*PKT_W-1:0]        push_data_i,
    output logic [$clog2(NRET+1)-1:0]    accept_cnt_o,
    input  logic                         pop_i,
    output logic [PKT_W-1:0]             head_o,
    output logic                         valid_o,
    output logic [$clog2(DEPTH):0]       level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(NRET + 1);

    logic [PKT_W-1:0] mem_q [DEPTH];
    logic [PKT_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             pop;
    logic [LW:0]      free;
    logic [CW-1:0]    accept;

    // Free space includes the slot released by a pop in the same cycle, so a
    // full FIFO that is being drained can still take one new record. Offered
    // records beyond the free space are simply not accepted.
    always_comb begin
        pop  = (level_q != '0) && pop_i;
        free = (LW+1)'(DEPTH) - {1'b0, level_q} + (LW+1)'(pop);
        if ((LW+1)'(push_cnt_i) > free) begin
            accept = free[CW-1:0];
        end else begin
            accept = push_cnt_i;
        end
    end

    // Write the accepted records at consecutive slots from the write pointer
    // (pointer arithmetic wraps naturally at DEPTH), and advance pointers
    // and level together so the level always matches the pointer distance.
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < NRET; i++) begin
            if (CW'(i) < accept) begin
                mem_d[wr_ptr_q + AW'(i)] = push_data_i[i*PKT_W +: PKT_W];
            end
        end
        wr_ptr_d = wr_ptr_q + AW'(accept);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d  = level_q + LW'(accept) - LW'(pop);
    end

    // Storage is reset as well so the head output reads zero after reset.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign head_o       = mem_q[rd_ptr_q];
    assign valid_o      = (level_q != '0);
    assign level_o      = level_q;
    assign accept_cnt_o = accept;

endmodule

// File: rtl/miriscv_rvfi_serializer.sv
// ---------------------------------------------------------------------------
// miriscv_rvfi_serializer
// Serializes up to NRET RVFI retirements per cycle into one packet per cycle
// (valid/ready), in program order, and checks rvfi_order continuity.
//   clk_i, arst_i        : clock, asynchronous active-high reset
//   rvfi_*_i             : per-lane RVFI fields, lane k at [k*W +: W]
//   pkt_valid_o/ready_i  : output handshake; pkt_o is the FIFO head
//   level_o              : FIFO occupancy
//   overflow_o           : sticky, a retirement was dropped for lack of space
//   order_err_o          : sticky, an order discontinuity was seen
//   err_order_o          : expected order at the first discontinuity
// ---------------------------------------------------------------------------
module miriscv_rvfi_serializer
    import miriscv_rvfi_pkg::*;
#(
    parameter int NRET        = 2,
    parameter int DEPTH       = 16,
    parameter bit CHECK_ORDER = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    arst_i,
    input  logic [NRET-1:0]         rvfi_valid_i,
    input  logic [NRET*64-1:0]      rvfi_order_i,
    input  logic [NRET*32-1:0]      rvfi_insn_i,
    input  logic [NRET-1:0]         rvfi_trap_i,
    input  logic [NRET*32-1:0]      rvfi_pc_rdata_i,
    input  logic [NRET*32-1:0]      rvfi_pc_wdata_i,
    input  logic [NRET*5-1:0]       rvfi_rd_addr_i,
    input  logic [NRET*32-1:0]      rvfi_rd_wdata_i,
    input  logic [NRET*32-1:0]      rvfi_mem_addr_i,
    input  logic [NRET*4-1:0]       rvfi_mem_rmask_i,
    input  logic [NRET*4-1:0]       rvfi_mem_wmask_i,
    input  logic [NRET*32-1:0]      rvfi_mem_rdata_i,
    input  logic [NRET*32-1:0]      rvfi_mem_wdata_i,
    output logic                    pkt_valid_o,
    input  logic                    pkt_ready_i,
    output logic [PKT_W-1:0]        pkt_o,
    output logic [$clog2(DEPTH):0]  level_o,
    output logic                    overflow_o,
    output logic                    order_err_o,
    output logic [63:0]             err_order_o
);

    localparam int CW = $clog2(NRET + 1);

    rvfi_pkt_t              lane_pkt [NRET];
    rvfi_pkt_t              comp_pkt [NRET];
    logic [CW-1:0]          push_cnt;
    logic [CW-1:0]          accept_cnt;
    logic [NRET*PKT_W-1:0]  push_data;

    logic [63:0]            expected_q, expected_d;
    logic                   first_seen_q, first_seen_d;
    logic                   order_err_q, order_err_d;
    logic [63:0]            err_order_q, err_order_d;
    logic                   overflow_q, overflow_d;

    // Gather each lane's slices of the flattened RVFI buses into one record.
    always_comb begin
        for (int k = 0; k < NRET; k++) begin
            lane_pkt[k].order     = rvfi_order_i[k*ORDER_W +: ORDER_W];
            lane_pkt[k].insn      = rvfi_insn_i[k*INSN_W +: INSN_W];
            lane_pkt[k].trap      = rvfi_trap_i[k];
            lane_pkt[k].pc_rdata  = rvfi_pc_rdata_i[k*XLEN +: XLEN];
            lane_pkt[k].pc_wdata  = rvfi_pc_wdata_i[k*XLEN +: XLEN];
            lane_pkt[k].rd_addr   = rvfi_rd_addr_i[k*REG_W +: REG_W];
            lane_pkt[k].rd_wdata  = rvfi_rd_wdata_i[k*XLEN +: XLEN];
            lane_pkt[k].mem_addr  = rvfi_mem_addr_i[k*XLEN +: XLEN];
            lane_pkt[k].mem_rmask = rvfi_mem_rmask_i[k*MASK_W +: MASK_W];
            lane_pkt[k].mem_wmask = rvfi_mem_wmask_i[k*MASK_W +: MASK_W];
            lane_pkt[k].mem_rdata = rvfi_mem_rdata_i[k*XLEN +: XLEN];
            lane_pkt[k].mem_wdata = rvfi_mem_wdata_i[k*XLEN +: XLEN];
        end
    end

    // Squeeze out invalid lanes so valid ones land in ascending lane order
    // at the front; this is program order for a superscalar retire.
    always_comb begin
        int unsigned n;
        n = 0;
        for (int k = 0; k < NRET; k++) begin
            comp_pkt[k] = '0;
        end
        for (int k = 0; k < NRET; k++) begin
            if (rvfi_valid_i[k]) begin
                comp_pkt[n] = lane_pkt[k];
                n = n + 1;
            end
        end
        push_cnt = CW'(n);
        for (int k = 0; k < NRET; k++) begin
            push_data[k*PKT_W +: PKT_W] = comp_pkt[k];
        end
    end

    miriscv_rvfi_mpfifo #(
        .NRET  (NRET),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .arst_i       (arst_i),
        .push_cnt_i   (push_cnt),
        .push_data_i  (push_data),
        .accept_cnt_o (accept_cnt),
        .pop_i        (pkt_ready_i),
        .head_o       (pkt_o),
        .valid_o      (pkt_valid_o),
        .level_o      (level_o)
    );

    // Order checker walks the accepted records as a chain, so a later lane
    // is compared against the earlier lane's order+1 within the same cycle.
    // After any mismatch it resynchronises to the received order; only the
    // first mismatch is recorded. Dropped records never reach the chain.
    always_comb begin
        expected_d   = expected_q;
        first_seen_d = first_seen_q;
        order_err_d  = order_err_q;
        err_order_d  = err_order_q;
        overflow_d   = overflow_q | (accept_cnt < push_cnt);
        for (int j = 0; j < NRET; j++) begin
            if (CW'(j) < accept_cnt) begin
                if (first_seen_d && (comp_pkt[j].order != expected_d) && !order_err_d) begin
                    order_err_d = 1'b1;
                    err_order_d = expected_d;
                end
                expected_d   = comp_pkt[j].order + 64'd1;
                first_seen_d = 1'b1;
            end
        end
    end

    // Checker and overflow state; all flags are sticky until reset.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            expected_q   <= '0;
            first_seen_q <= 1'b0;
            order_err_q  <= 1'b0;
            err_order_q  <= '0;
            overflow_q   <= 1'b0;
        end else begin
            expected_q   <= expected_d;
            first_seen_q <= first_seen_d;
            order_err_q  <= order_err_d;
            err_order_q  <= err_order_d;
            overflow_q   <= overflow_d;
        end
    end

    assign overflow_o  = overflow_q;
    assign order_err_o = CHECK_ORDER ? order_err_q : 1'b0;
    assign err_order_o = CHECK_ORDER ? err_order_q : 64'd0;

endmodule

// File: doc/miriscv_rvfi_serializer.md
Name: miriscv_rvfi_serializer

Overview:
- Sits between the miriscv_core RVFI outputs and the trace/scoreboard consumer.
- Accepts up to NRET retirement lanes per cycle, with no backpressure to the core, and buffers them in a FIFO.
- Emits one retired-instruction packet per cycle, in program order, over a valid/ready handshake.
- Checks rvfi_order continuity and flags overflow and order errors for the verification environment.

Parameters:
- NRET, 2, retirement lanes per cycle (1..4).
- DEPTH, 16, FIFO entries; power of two, DEPTH >= 2*NRET.
- CHECK_ORDER, 1, enable the order-continuity checker.

Ports:
- clk_i  in  1  clock.
- arst_i  in  1  asynchronous active-high reset.
- rvfi_valid_i  in  NRET  per-lane retire strobe.
- rvfi_order_i  in  NRET*64  per-lane order.
- rvfi_insn_i  in  NRET*32  instruction word.
- rvfi_trap_i  in  NRET  trap flag.
- rvfi_pc_rdata_i  in  NRET*32  PC of the instruction.
- rvfi_pc_wdata_i  in  NRET*32  next PC.
- rvfi_rd_addr_i  in  NRET*5  destination register.
- rvfi_rd_wdata_i  in  NRET*32  destination write data.
- rvfi_mem_addr_i  in  NRET*32  memory address.
- rvfi_mem_rmask_i  in  NRET*4  read byte mask.
- rvfi_mem_wmask_i  in  NRET*4  write byte mask.
- rvfi_mem_rdata_i  in  NRET*32  load data.
- rvfi_mem_wdata_i  in  NRET*32  store data.
- pkt_valid_o  out  1  output packet valid.
- pkt_ready_i  in  1  consumer ready.
- pkt_o  out  $bits(rvfi_pkt_t)  head packet.
- level_o  out  $clog2(DEPTH)+1  current occupancy.
- overflow_o  out  1  sticky: a retirement was dropped.
- order_err_o  out  1  sticky: order discontinuity.
- err_order_o  out  64  expected order at the first error.

Behaviour:
- Reset (async assert, sync release), all registers cleared:
  - pkt_valid_o=0, pkt_o=0, level_o=0.
  - overflow_o=0, order_err_o=0, err_order_o=0.
  - Expected-order register = 0; first_seen=0.
- Lane-to-packet mapping: lane k occupies bits [k*W +: W] of each flattened input.
- Push, same cycle:
  - Valid lanes are compacted in ascending lane index.
  - They are written at wr_ptr, wr_ptr+1, ... (mod DEPTH).
  - Any valid-lane pattern is legal, e.g. 2'b10 pushes only lane 1.
- Pop: occurs when pkt_valid_o && pkt_ready_i; rd_ptr advances by 1.
- Output timing:
  - pkt_o is driven combinationally from the entry at rd_ptr.
  - pkt_valid_o = (level != 0).
  - Minimum input-to-output latency is 1 cycle; no bypass.
- Stability: while pkt_valid_o=1 and pkt_ready_i=0, pkt_o holds stable.
- Simultaneous push and pop:
  - Free space counts the slot freed by the pop this cycle.
  - level_next = level + pushes - pop.
- Full / overflow:
  - If pushes exceed free space, accept lanes in ascending order until full and drop the rest.
  - overflow_o sets next cycle and stays set until reset.
  - Pointers never wrap past rd_ptr.
- Empty: pkt_valid_o=0; a pop attempt is ignored.
- Pointer wrap-around: modulo DEPTH via $clog2(DEPTH)-bit pointers plus the separate level counter.
- Order checker (CHECK_ORDER=1), applied to accepted lanes in compaction order:
  - The first accepted packet after reset seeds expected = order+1 with no check.
  - Each later packet must equal expected; then expected increments.
  - On the first mismatch: order_err_o sets (sticky) and err_order_o captures the expected value.
  - Checking continues with expected = received order+1.
  - Multiple lanes in one cycle are checked as a chain: lane 1 is checked against lane 0's order+1.
  - Dropped (overflowed) lanes are not checked.
- CHECK_ORDER=0: order_err_o and err_order_o are tied to 0.
- Reset mid-operation: all contents are discarded immediately, pointers zeroed, and sticky flags cleared.

Decomposition:
- Package miriscv_rvfi_pkg:
  - rvfi_pkt_t packed struct: order, insn, trap, pc_rdata, pc_wdata, rd_addr, rd_wdata, mem_addr, mem_rmask, mem_wmask, mem_rdata, mem_wdata.
  - Field width localparams.
- Sub-module miriscv_rvfi_mpfifo:
  - Generic multi-push (NRET), single-pop FIFO on rvfi_pkt_t.
  - Owns the pointers and level counter, and reports the accept count.
- The top level handles lane unpacking, compaction and the order checker.

Test Plan:
- Single lane: valid=01 with order 0..4, ready=1 -> packets 0..4 on consecutive cycles, each 1 cycle after input; level_o peaks at 1; no flags.
- Dual lane: valid=11 with orders (0,1),(2,3), ready=1 -> output order 0,1,2,3; level_o peaks at 3; order_err_o=0.
- Lane-1-only: valid=10 with order 7 as first packet -> seeds expected=8; next valid=01 with order 8 -> no error.
- Backpressure and overflow:
  - DEPTH=16, ready=0, valid=11 for 9 cycles -> 16 accepted, 2 dropped, overflow_o=1, level_o=16.
  - Then ready=1 -> orders 0..15 out, followed by a clean empty state.
- Order gap: orders 0,1,3 -> order_err_o=1, err_order_o=2; subsequent order 4 produces no further capture.
- Reset mid-stream: arst_i pulsed with level_o=5 and both flags set -> pkt_valid_o=0, level_o=0, flags=0 asynchronously; the next packet with order 100 is accepted without error.
